// File: rtl/multi_tap_delay_sr.sv
// Multi-tap circular delay line: one storage ring, NUM_TAPS read taps, each delayed by its own count of accepted words.
// Optional runtime-programmable tap delays when MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN is defined.
module multi_tap_delay_sr #(
  parameter int                       DATA_W     = 16,
  parameter int                       DEPTH      = 67,
  parameter int                       NUM_TAPS   = 4,
  parameter logic [NUM_TAPS*16-1:0]   TAP_DELAYS = {16'd2, 16'd1, 16'd65, 16'd66}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_en,
  input  logic [DATA_W-1:0]           in,
`ifdef MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN
  input  logic                        cfg_we,
  input  logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0] cfg_idx,
  input  logic [15:0]                 cfg_delay,
`endif
  output logic [DATA_W-1:0]           tap_out [NUM_TAPS-1:0],
  output logic [NUM_TAPS-1:0]         tap_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int IW = AW + 1;

  logic [AW-1:0]     wp;
  logic [FW-1:0]     fill;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [15:0]       dly [NUM_TAPS];

  function automatic logic [AW-1:0] rd_idx(input logic [AW-1:0] p, input logic [15:0] d);
    logic [IW-1:0] pe;
    logic [IW-1:0] de;
    logic [IW-1:0] s;
    pe = {1'b0, p};
    de = IW'(d);
    s  = (pe >= de) ? (pe - de) : (pe + IW'(DEPTH) - de);
    return AW'(s);
  endfunction

  function automatic logic [FW-1:0] sat_fill(input logic [FW-1:0] f);
    return (f == FW'(DEPTH)) ? f : f + 1'b1;
  endfunction

  function automatic logic [AW-1:0] next_wp(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_chk
    if (TAP_DELAYS[16*k +: 16] > DEPTH) begin : g_bad
      $error("multi_tap_delay_sr: tap %0d delay exceeds DEPTH %0d", k, DEPTH);
    end
  end

`ifdef MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN
  function automatic logic [15:0] clamp_delay(input logic [15:0] d);
    return (d > 16'(DEPTH)) ? 16'(DEPTH) : d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) dly[k] <= TAP_DELAYS[16*k +: 16];
    end else if (cfg_we) begin
      // Out-of-range indices match no tap and are dropped.
      for (int k = 0; k < NUM_TAPS; k++)
        if (32'(cfg_idx) == k) dly[k] <= clamp_delay(cfg_delay);
    end
  end
`else
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_dly
    assign dly[k] = TAP_DELAYS[16*k +: 16];
  end
`endif

  // Write stage: pointer and fill count are control (reset); storage is data (not reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      fill <= '0;
    end else if (flush) begin
      wp   <= '0;
      fill <= '0;
    end else if (in_en) begin
      wp   <= next_wp(wp);
      fill <= sat_fill(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (in_en && !flush) mem[wp] <= in;
  end

  // Read stage: combinational from registered state, pre-write, so a delay of DEPTH sees the slot before it is overwritten.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap_valid[k] = 1'b0;
      tap_out[k]   = '0;
      if (dly[k] == 16'd0) begin
        tap_valid[k] = in_en;
        tap_out[k]   = in;
      end else if (16'(fill) >= dly[k]) begin
        tap_valid[k] = 1'b1;
        tap_out[k]   = mem[rd_idx(wp, dly[k])];
      end
    end
  end

endmodule

// File: tb/tb_multi_tap_delay_sr.sv
// Randomised bench for multi_tap_delay_sr: three depths share stimulus and are checked every cycle against a history-queue model.
module tb_multi_tap_delay_sr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_en = 1'b0;
  logic [15:0] din = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_delay = '0;

  logic [15:0] out0 [3:0];
  logic [15:0] out1 [3:0];
  logic [15:0] out2 [3:0];
  logic [3:0]  val0, val1, val2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_tap_delay_sr #(.DATA_W(16), .DEPTH(67), .NUM_TAPS(4),
    .TAP_DELAYS({16'd2, 16'd1, 16'd65, 16'd66})) u_d67 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_en(in_en), .in(din),
`ifdef MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_delay(cfg_delay),
`endif
    .tap_out(out0), .tap_valid(val0));

  multi_tap_delay_sr #(.DATA_W(16), .DEPTH(64), .NUM_TAPS(4),
    .TAP_DELAYS({16'd2, 16'd1, 16'd63, 16'd64})) u_d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_en(in_en), .in(din),
`ifdef MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN
    .cfg_we(1'b0), .cfg_idx(2'd0), .cfg_delay(16'd0),
`endif
    .tap_out(out1), .tap_valid(val1));

  multi_tap_delay_sr #(.DATA_W(16), .DEPTH(5), .NUM_TAPS(4),
    .TAP_DELAYS({16'd0, 16'd1, 16'd4, 16'd5})) u_d5 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_en(in_en), .in(din),
`ifdef MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN
    .cfg_we(1'b0), .cfg_idx(2'd0), .cfg_delay(16'd0),
`endif
    .tap_out(out2), .tap_valid(val2));

  // Model: words accepted since the last flush/reset; tap k shows the word D acceptances back.
  logic [15:0] hist [$];
  int          n = 0;
  int          dly [3][4] = '{'{66, 65, 1, 2}, '{64, 63, 1, 2}, '{5, 4, 1, 0}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      n = 0;
      dly[0] = '{66, 65, 1, 2};
    end else begin
      if (cfg_we) dly[0][cfg_idx] = (cfg_delay > 16'd67) ? 67 : int'(cfg_delay);
      if (flush) begin
        hist.delete();
        n = 0;
      end else if (in_en) begin
        hist.push_back(din);
        n++;
        if (hist.size() > 200) void'(hist.pop_front());
      end
    end
  end

  task automatic cmp(input int u, input int k, input logic [15:0] got, input logic gv);
    int          d;
    logic [15:0] e;
    logic        ev;
    d = dly[u][k];
    if (d == 0) begin
      e = din; ev = in_en;
    end else if (n >= d) begin
      e = hist[hist.size() - d]; ev = 1'b1;
    end else begin
      e = '0; ev = 1'b0;
    end
    checks++;
    if (got !== e || gv !== ev) begin
      errors++;
      $display("FAIL tap dut%0d k%0d @%0t: got valid=%0b out=%0d, want valid=%0b out=%0d",
               u, k, $time, gv, got, ev, e);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      cmp(0, k, out0[k], val0[k]);
      cmp(1, k, out1[k], val1[k]);
      cmp(2, k, out2[k], val2[k]);
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic cyc(input bit f, input bit e, input logic [15:0] d);
    flush = f; in_en = e; din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic int or_outs();
    return int'(out0[0] | out0[1] | out0[2] | out0[3]);
  endfunction

  initial begin
    // Reset with input toggling.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 16'($urandom));
      chk("reset_valid", int'(val0), 0);
      chk("reset_out", or_outs(), 0);
    end
    rst_n = 1'b1;
    cyc(0, 0, 16'($urandom));
    chk("post_release_valid", int'(val0), 0);
    chk("post_release_out", or_outs(), 0);

    // Stream 0,1,2,...
    for (int i = 0; i < 70; i++) begin
      cyc(0, 1, 16'(i));
      if (i == 64) chk("tap0_not_yet_valid", int'(val0[0]), 0);
      if (i == 65) begin
        chk("tap0_first_valid", int'(val0[0]), 1);
        chk("tap0_first_value", int'(out0[0]), 0);
      end
    end
    chk("stream70_tap3", int'(out0[3]), 68);
    chk("stream70_tap2", int'(out0[2]), 69);
    chk("stream70_tap1", int'(out0[1]), 5);
    chk("stream70_tap0", int'(out0[0]), 4);
    chk("stream70_valid", int'(val0), 15);
    for (int i = 70; i < 80; i++) cyc(0, 1, 16'(i));

    // Stall, then resume and run across several wraps.
    for (int i = 0; i < 10; i++) cyc(0, 0, 16'($urandom));
    chk("stall_tap2_hold", int'(out0[2]), 79);
    chk("stall_tap0_hold", int'(out0[0]), 14);
    for (int i = 80; i < 80 + 3 * 67 + 5; i++) cyc(0, 1, 16'(i));
    chk("wrap_tap2", int'(out0[2]), 285);
    chk("wrap_tap0", int'(out0[0]), 220);
    chk("wrap_d5_tap0", int'(out2[0]), 281);

    // Random enables, data and occasional flushes.
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 16'($urandom));

    // Flush colliding with a write.
    cyc(1, 0, 16'd0);
    for (int i = 0; i < 99; i++) cyc(0, 1, 16'(1000 + i));
    cyc(1, 1, 16'd999);
    chk("flush_valid", int'(val0), 0);
    chk("flush_out", or_outs(), 0);
    cyc(0, 1, 16'd1234);
    chk("flush_tap2_valid", int'(val0[2]), 1);
    chk("flush_tap2_out", int'(out0[2]), 1234);
    chk("flush_tap0_valid", int'(val0[0]), 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 16'($urandom));

    // Mid-cycle asynchronous reset.
    for (int i = 0; i < 30; i++) cyc(0, 1, 16'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(val0), 0);
    chk("async_rst_out", or_outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 16'd0);

`ifdef MULTI_TAP_DELAY_SR_RUNTIME_TAPS_EN
    for (int i = 0; i < 20; i++) cyc(0, 1, 16'(i));
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_delay = 16'd5;
    cyc(0, 0, 16'd0);
    cfg_we = 1'b0;
    chk("cfg_tap2_valid", int'(val0[2]), 1);
    chk("cfg_tap2_out", int'(out0[2]), 15);
    cfg_we = 1'b1; cfg_delay = 16'd200;
    cyc(0, 0, 16'd0);
    cfg_we = 1'b0;
    chk("cfg_clamp_not_full", int'(val0[2]), 0);
    for (int i = 20; i < 70; i++) cyc(0, 1, 16'(i));
    chk("cfg_clamp_valid", int'(val0[2]), 1);
    chk("cfg_clamp_out", int'(out0[2]), 3);
`endif

    for (int i = 0; i < 40; i++)
      cyc(0, $urandom_range(0, 3) != 0, 16'($urandom));
    cyc(0, 0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
